// File: rtl/motor_bridge_pkg.sv
// Shared state encoding, register offsets and register bit positions for motor_bridge_ctrl.
// Definitions only: no latency and no backpressure.
package motor_bridge_pkg;

  typedef enum logic [2:0] {
    ST_COAST = 3'd0,
    ST_DRIVE = 3'd1,
    ST_BRAKE = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } bridgeState_t;

  // Register offsets, decoded from bus_addr[3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_DEADTIME = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_REVCOUNT = 2'd3;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_BRAKE       = 1;
  localparam int CTRL_USE_BUS_DIR = 2;
  localparam int CTRL_BUS_DIR     = 3;
  localparam int CTRL_IRQ_EN      = 4;

  localparam int STATUS_FAULT_LATCHED = 3;
  localparam int STATUS_FAULT_SYNC    = 4;
  localparam int STATUS_CUR_DIR       = 5;

endpackage

// File: rtl/motor_bridge_ctrl_sync.sv
// bridge_sync: two-flop synchronizer that resets to 0.
// Latency is 2 pclk cycles and there is no backpressure.
module bridge_sync (
  input  logic pclk,
  input  logic nreset,
  input  logic asyncIn,
  output logic syncOut
);

  logic metaFlop;

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      metaFlop <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      metaFlop <= asyncIn;
      syncOut  <= metaFlop;
    end
  end

endmodule

// File: rtl/motor_bridge_ctrl.sv
// H-bridge driver with dead-time on reversal and brake, fault latching, and a register-mapped control interface.
// Outputs are 1 cycle after state/pwm_in, read data is 1 cycle after bus_read_en, and there is no backpressure.
module motor_bridge_ctrl
  import motor_bridge_pkg::*;
#(
  parameter int DT_WIDTH = 16,
  parameter int DT_RESET = 50
) (
  input  logic        pclk,
  input  logic        nreset,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic [7:0]  bus_addr,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  input  logic        pwm_in,
  input  logic        dir_in,
  input  logic        fault_n,
  output logic        hb_in1,
  output logic        hb_in2,
  output logic        hb_en,
  output logic        fault_irq
);

  logic [4:0]          ctrlReg;
  logic [DT_WIDTH-1:0] deadTime;
  logic [15:0]         revCount;
  logic                faultLatched;
  logic                faultSync;

  bridgeState_t        state, stateNext;
  logic                curDir, curDirNext;
  logic [DT_WIDTH-1:0] dtCnt, dtCntNext;
  logic                deadToBrake, deadToBrakeNext;
  logic                revInc;

  logic enable, brake, effDir;
  logic wrCtrl, wrDeadTime, wrStatus, wrRevCount, rdStrobe;
  logic [31:0] statusWord, readMux;
  logic unusedBits;

  assign unusedBits = ^{bus_addr[7:4], bus_addr[1:0], bus_write_data[31:DT_WIDTH]};

  bridge_sync uFaultSync (
    .pclk    (pclk),
    .nreset  (nreset),
    .asyncIn (~fault_n),
    .syncOut (faultSync)
  );

  assign enable = ctrlReg[CTRL_ENABLE];
  assign brake  = ctrlReg[CTRL_BRAKE];
  assign effDir = ctrlReg[CTRL_USE_BUS_DIR] ? ctrlReg[CTRL_BUS_DIR] : dir_in;

  assign wrCtrl     = bus_write_en && (bus_addr[3:2] == REG_CTRL);
  assign wrDeadTime = bus_write_en && (bus_addr[3:2] == REG_DEADTIME);
  assign wrStatus   = bus_write_en && (bus_addr[3:2] == REG_STATUS);
  assign wrRevCount = bus_write_en && (bus_addr[3:2] == REG_REVCOUNT);
  assign rdStrobe   = bus_read_en && !bus_write_en;

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_COAST;
      curDir      <= 1'b0;
      dtCnt       <= '0;
      deadToBrake <= 1'b0;
    end else begin
      state       <= stateNext;
      curDir      <= curDirNext;
      dtCnt       <= dtCntNext;
      deadToBrake <= deadToBrakeNext;
    end
  end

  // Priority: fault > ~enable > brake > direction change
  always_comb begin
    stateNext       = state;
    curDirNext      = curDir;
    dtCntNext       = dtCnt;
    deadToBrakeNext = deadToBrake;
    revInc          = 1'b0;
    if (faultSync) begin
      stateNext = ST_FAULT;
    end else begin
      case (state)
        ST_COAST: begin
          if (enable && brake) begin
            stateNext       = ST_DEAD;
            deadToBrakeNext = 1'b1;
            dtCntNext       = deadTime;
          end else if (enable) begin
            stateNext  = ST_DRIVE;
            curDirNext = effDir;
          end
        end
        ST_DRIVE: begin
          if (!enable) begin
            stateNext = ST_COAST;
          end else if (brake) begin
            stateNext       = ST_DEAD;
            deadToBrakeNext = 1'b1;
            dtCntNext       = deadTime;
          end else if (effDir != curDir) begin
            stateNext       = ST_DEAD;
            deadToBrakeNext = 1'b0;
            dtCntNext       = deadTime;
          end
        end
        ST_BRAKE: begin
          if (!enable) begin
            stateNext = ST_COAST;
          end else if (!brake) begin
            stateNext       = ST_DEAD;
            deadToBrakeNext = 1'b0;
            dtCntNext       = deadTime;
          end
        end
        ST_DEAD: begin
          if (!enable) begin
            stateNext = ST_COAST;
          end else begin
            // Brake during a reversal retargets without restarting the count
            if (brake) deadToBrakeNext = 1'b1;
            if (dtCnt == '0) begin
              if (brake || deadToBrake) begin
                stateNext = ST_BRAKE;
              end else begin
                stateNext  = ST_DRIVE;
                curDirNext = effDir;
                revInc     = (effDir != curDir);
              end
            end else begin
              dtCntNext = dtCnt - DT_WIDTH'(1);
            end
          end
        end
        ST_FAULT: begin
          if (!faultLatched) stateNext = ST_COAST;
        end
        default: stateNext = ST_COAST;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      ctrlReg       <= '0;
      deadTime      <= DT_WIDTH'(DT_RESET);
      revCount      <= '0;
      faultLatched  <= 1'b0;
      bus_read_data <= '0;
      fault_irq     <= 1'b0;
    end else begin
      if (wrCtrl) ctrlReg <= bus_write_data[4:0];
      if (wrDeadTime) deadTime <= bus_write_data[DT_WIDTH-1:0];
      if (wrRevCount) revCount <= '0;
      else if (revInc) revCount <= revCount + 16'd1;
      // A clear while the fault persists is re-latched on the following cycle
      if (wrStatus && bus_write_data[STATUS_FAULT_LATCHED]) faultLatched <= 1'b0;
      else if (faultSync) faultLatched <= 1'b1;
      if (rdStrobe) bus_read_data <= readMux;
      fault_irq <= faultLatched & ctrlReg[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    statusWord                       = '0;
    statusWord[2:0]                  = state;
    statusWord[STATUS_FAULT_LATCHED] = faultLatched;
    statusWord[STATUS_FAULT_SYNC]    = faultSync;
    statusWord[STATUS_CUR_DIR]       = curDir;
  end

  always_comb begin
    readMux = '0;
    case (bus_addr[3:2])
      REG_CTRL:     readMux = {27'd0, ctrlReg};
      REG_DEADTIME: readMux = {{(32-DT_WIDTH){1'b0}}, deadTime};
      REG_STATUS:   readMux = statusWord;
      REG_REVCOUNT: readMux = {16'd0, revCount};
      default:      readMux = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      hb_in1 <= 1'b0;
      hb_in2 <= 1'b0;
      hb_en  <= 1'b0;
    end else begin
      case (state)
        ST_DRIVE: begin
          hb_in1 <= curDir ? 1'b0 : pwm_in;
          hb_in2 <= curDir ? pwm_in : 1'b0;
          hb_en  <= 1'b1;
        end
        ST_BRAKE: begin
          hb_in1 <= 1'b1;
          hb_in2 <= 1'b1;
          hb_en  <= 1'b1;
        end
        default: begin
          hb_in1 <= 1'b0;
          hb_in2 <= 1'b0;
          hb_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule
